// File: rtl/ps2_mouse_cursor.sv
// ps2_mouse_cursor: receive-only PS/2 mouse decoder.
// The block deserializes device-to-host frames and assembles 3-byte movement
// packets. It integrates a clamped cursor position and holds the button levels.
module ps2_mouse_cursor #(
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239,
  parameter int X_INIT  = 160,
  parameter int Y_INIT  = 120,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       left,
  output logic       right,
  output logic       packet_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Header fields of byte 0 that the position update needs.
  typedef struct packed {
    logic yo;
    logic xo;
    logic ys;
    logic xs;
    logic r;
    logic l;
  } hdr_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] idle_cnt;
  logic          timeout;
  state_t        state_q, state_d;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity_ok;
  logic          byte_ok, frame_bad;
  logic [1:0]    idx;
  hdr_t          hdr;
  logic [7:0]    b1;
  logic          din;

  assign din     = data_sync[1];
  assign timeout = (state_q != IDLE) && (idle_cnt == TW'(TIMEOUT));

  // Two-flop synchronizers for both asynchronous PS/2 lines (idle high).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: accept a new clock level after FILTER equal samples; flag falling edges.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Idle counter: cleared by every sampled edge, saturates at TIMEOUT.
  always_ff @(posedge clk_100MHz) begin
    if (reset || fall || timeout) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame FSM next state plus byte-accept / frame-error strobes.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:   if (!din) state_d = DATA;
        DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (din && parity_ok) byte_ok   = 1'b1;
          else                  frame_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame datapath: LSB-first shift register, bit counter, parity verdict.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      shift     <= '0;
      bit_cnt   <= '0;
      parity_ok <= 1'b0;
    end else if (fall && !timeout) begin
      unique case (state_q)
        IDLE:   bit_cnt <= '0;
        DATA: begin
          shift   <= {din, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: parity_ok <= ^{shift, din};
        default: ;
      endcase
    end
  end

  // Candidate position from the stored header, byte 1 and the byte in the shifter.
  logic signed [10:0] dx, dy, nx, ny;
  logic [8:0]         x_next, y_next;
  always_comb begin
    dx = hdr.xo ? 11'sd0 : $signed({{3{hdr.xs}}, b1});
    dy = hdr.yo ? 11'sd0 : $signed({{3{hdr.ys}}, shift});
    nx = $signed({2'b00, xm}) + dx;
    ny = $signed({2'b00, ym}) - dy;
    if (nx < 0)            x_next = '0;
    else if (nx > X_MAX_S) x_next = X_MAX_S[8:0];
    else                   x_next = nx[8:0];
    if (ny < 0)            y_next = '0;
    else if (ny > Y_MAX_S) y_next = Y_MAX_S[8:0];
    else                   y_next = ny[8:0];
  end

  // Packet assembly, resync on byte 0 bit 3, output update on byte 2.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      idx          <= '0;
      hdr          <= '0;
      b1           <= '0;
      xm           <= 9'(X_INIT);
      ym           <= 9'(Y_INIT);
      left         <= 1'b0;
      right        <= 1'b0;
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= frame_bad | timeout;
      if (frame_bad || timeout) begin
        idx <= '0;
      end else if (byte_ok) begin
        unique case (idx)
          2'd0: if (shift[3]) begin
            hdr <= '{yo: shift[7], xo: shift[6], ys: shift[5], xs: shift[4],
                     r: shift[1], l: shift[0]};
            idx <= 2'd1;
          end
          2'd1: begin
            b1  <= shift;
            idx <= 2'd2;
          end
          default: begin
            xm           <= x_next;
            ym           <= y_next;
            left         <= hdr.l;
            right        <= hdr.r;
            packet_valid <= 1'b1;
            idx          <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Testbench for ps2_mouse_cursor: bit-banged PS/2 frames, scoreboard of expected cursor states.
module tb_ps2_mouse_cursor;

  localparam int HALF = 30;    // half bit period in system clocks
  localparam int TO   = 2000;  // shortened timeout to keep the run short

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] xm, ym;
  logic       left, right, packet_valid, frame_err;

  ps2_mouse_cursor #(.TIMEOUT(TO)) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .xm          (xm),
    .ym          (ym),
    .left        (left),
    .right       (right),
    .packet_valid(packet_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit l;
    bit r;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_tests = 0, n_fail = 0;
  int   err_seen = 0, exp_err = 0;
  int   mx = 160, my = 120;
  bit   ml = 1'b0, mr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of one packet; pushes the expected cursor state.
  task automatic model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int   dx, dy;
    exp_t e;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = mx + dx;
    my = my - dy;
    if (mx < 0) mx = 0;
    if (mx > 319) mx = 319;
    if (my < 0) my = 0;
    if (my > 239) my = 239;
    ml = b0[0];
    mr = b0[1];
    e.x = mx; e.y = my; e.l = ml; e.r = mr;
    sb.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    model(b0, b1, b2);
    send_frame(b0, 1'b0);
    send_frame(b1, 1'b0);
    send_frame(b2, 1'b0);
    repeat (20) @(negedge clk);
    check("pkt_drain", sb.size(), 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, xm, mx);
    check({tag, "_y"}, ym, my);
    check({tag, "_l"}, left, ml);
    check({tag, "_r"}, right, mr);
  endtask

  // Monitor: compare each packet_valid against the scoreboard, count frame_err cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (packet_valid) begin
        check("pv_excl_ferr", frame_err, 0);
        check("pv_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          check("pkt_x", xm, e_mon.x);
          check("pkt_y", ym, e_mon.y);
          check("pkt_l", left, e_mon.l);
          check("pkt_r", right, e_mon.r);
        end
      end
      if (frame_err) err_seen++;
    end
  end

  initial begin
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("rst");
    check("rst_pv", packet_valid, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b0;

    // Basic packet with left button.
    send_packet(8'h09, 8'h05, 8'h03);
    // Move to (318,1), then clamp high on both axes.
    send_packet(8'h08, 8'h99, 8'h74);
    send_packet(8'h08, 8'h0A, 8'h05);

    // Reset mid-frame: no frame_err, back to the initial position.
    send_partial(5);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    mx = 160; my = 120; ml = 1'b0; mr = 1'b0;
    reset = 1'b0;
    repeat (TO + 500) @(negedge clk);
    check("rst_mid_ferr", err_seen, exp_err);
    check_outputs("rst_mid");

    // Clamp low (dx = -200), then X overflow forces dx to 0.
    send_packet(8'h18, 8'h38, 8'h00);
    send_packet(8'h48, 8'h7F, 8'h02);

    // Parity error on byte 1: one frame_err, outputs hold, next packet normal.
    send_frame(8'h08, 1'b0);
    send_frame(8'h05, 1'b1);
    exp_err++;
    repeat (20) @(negedge clk);
    check("par_ferr", err_seen, exp_err);
    check_outputs("par_hold");
    send_packet(8'h09, 8'h05, 8'h03);

    // Resync: stray byte without bit 3 is dropped.
    send_frame(8'h00, 1'b0);
    send_packet(8'h0A, 8'h02, 8'h01);

    // Timeout after 5 bits, then a packet with negative dy.
    send_partial(5);
    repeat (TO + 500) @(negedge clk);
    exp_err++;
    check("to_ferr", err_seen, exp_err);
    check_outputs("to_hold");
    send_packet(8'h28, 8'h01, 8'hFF);

    check("final_ferr", err_seen, exp_err);
    check("final_sb", sb.size(), 0);
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_cursor.md
# ps2_mouse_cursor

Receive-only PS/2 mouse decoder for the TicTacToe board. It deserializes 11-bit PS/2 device-to-host frames and assembles standard 3-byte movement packets. From those packets it integrates a clamped 9-bit cursor position (`xm`, `ym`) and button levels (`left`, `right`), which the VGA painter consumes directly. Sending the stream-mode enable command (0xF4) is the job of a separate block; this block never drives the PS/2 lines.

## Interface
Parameters:
- `X_MAX`, default 319: largest x coordinate; x is clamped to [0, X_MAX].
- `Y_MAX`, default 239: largest y coordinate; y is clamped to [0, Y_MAX].
- `X_INIT`, default 160: reset value of `xm`.
- `Y_INIT`, default 120: reset value of `ym`.
- `FILTER`, default 8: number of consecutive equal samples needed to accept a new `ps2_clk` level.
- `TIMEOUT`, default 200000: number of idle cycles (2 ms at 100 MHz) that aborts a partial frame.

Ports:
- `clk_100MHz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `xm`  out  9  cursor x, unsigned.
- `ym`  out  9  cursor y, unsigned; 0 is the top row.
- `left`  out  1  left button level.
- `right`  out  1  right button level.
- `packet_valid`  out  1  one-cycle pulse when a packet is applied.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- **Input conditioning.** Both PS/2 inputs pass through 2-FF synchronizers. The filtered clock level changes only after `FILTER` consecutive equal synced samples. A falling edge of the filtered clock samples synced `ps2_data`.
- **Frame FSM.**
  - States are IDLE, DATA, PARITY, STOP.
  - IDLE: an edge with data=0 goes to DATA. An edge with data=1 is ignored.
  - DATA: 8 edges shift bits in LSB first, then go to PARITY.
  - PARITY: the sampled bit must make the 9 bits odd parity. Go to STOP.
  - STOP: the sampled bit must be 1. On success, deliver the byte to the packet stage. On a parity or stop failure, pulse `frame_err`. Either way return to IDLE.
- **Timeout.** An idle counter clears on every accepted edge. If it reaches `TIMEOUT` while the FSM is not in IDLE, the FSM returns to IDLE, `frame_err` pulses, and the packet index resets to 0.
- **Packet stage.**
  - The byte index takes values 0, 1, 2.
  - A byte at index 0 with bit3=0 is discarded and the index stays 0. This is the resync rule.
  - Any frame error resets the index to 0 and discards partial packet bytes.
- **Byte 0 fields.** bit0=L, bit1=R, bit4=X sign, bit5=Y sign, bit6=X overflow, bit7=Y overflow.
- **Deltas.**
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, both 9-bit two's complement.
  - A delta whose overflow bit is set is forced to 0.
- **Position update.**
  - nx = xm + sext(dx) and ny = ym − sext(dy), computed as 11-bit signed values.
  - A result < 0 becomes 0. A result > MAX becomes MAX.
  - Mouse +Y means up on the mouse, which is a decreasing screen y.
- **Output update.** When byte 2 completes: `xm`, `ym`, `left`, `right` all update, `packet_valid` pulses, and the index returns to 0.
- **Reset values.** `xm`=X_INIT, `ym`=Y_INIT. `left`, `right`, `packet_valid`, `frame_err` = 0. FSM = IDLE, index = 0, all counters = 0.
- **Reset mid-frame.** Reset abandons the frame and the partial packet with no `frame_err` pulse.

## Timing
- The filtered clock reaches the FSM 2 + `FILTER` cycles after the raw pin changes.
- Byte 2's stop bit is sampled at filtered falling edge T. The outputs change, and `packet_valid`=1, in cycle T+1.
- `frame_err` is asserted in cycle T+1 of the failing stop/parity sample, or in the cycle after the timeout count is reached.
- `packet_valid` and `frame_err` are never high together.
- Between updates, the outputs hold their values.
- The minimum supported PS/2 bit period is 4·`FILTER` + 8 system clocks.

## Test plan
- Reset, then packet 0x09, 0x05, 0x03 → `xm`=165, `ym`=117, `left`=1, `right`=0, one `packet_valid` pulse.
- Clamp high: starting at `xm`=318, `ym`=1, send packet 0x08, 0x0A, 0x05 → `xm`=319, `ym`=0.
- Clamp low: from (160,120), send 0x18, 0x38, 0x00 (dx=−200) → `xm`=0, `ym`=120.
- Overflow: send 0x48, 0x7F, 0x02 → `xm` unchanged, `ym` decreases by 2.
- Parity error: send a bad byte 1 → `frame_err` pulses and outputs are unchanged. The following valid packet applies normally.
- Resync and timeout:
  - A stray byte 0x00 followed by a valid packet → only the valid packet applies.
  - 5 bits, then 3 ms of silence → `frame_err` pulses. The next packet decodes correctly.
